i2c_target_regbank: RTL and testbench

//  I2C target (slave) exposing a byte-wide register bank to an external I2C controller.

---
 rtl/i2c_target_regbank.sv | 243 ++++++++++++++++++++++++
 tb/tb_i2c_target_regbank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regbank.sv
// I2C target exposing a 2**AW byte register bank, with a local read/write port.
// Optional input glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regbank #(
  parameter logic [6:0] DEV_ADDR = 7'h4C,
  parameter int         AW       = 6,
  parameter int         FILT_LEN = 3
) (
  input  logic          i_sysclk,
  input  logic          i_arst,
  input  logic          i_scl,
  input  logic          i_sda,
  output logic          o_sda_oe,
  input  logic          i_usr_we,
  input  logic [AW-1:0] i_usr_addr,
  input  logic [7:0]    i_usr_din,
  output logic [7:0]    o_usr_dout,
  output logic          o_wr_stb,
  output logic [AW-1:0] o_wr_addr,
  output logic [7:0]    o_wr_data,
  output logic          o_busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_ACK_A, S_PTR, S_ACK_P,
    S_WDATA, S_ACK_W, S_RDATA, S_MACK
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [7:0]    sh, sh_nxt;
  logic [7:0]    tx, tx_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          oe, oe_nxt;
  logic          busy, busy_nxt;
  logic          bank_we, i2c_we;
  logic [7:0]    rd_byte;
  logic [7:0]    bank [2**AW];

  logic scl_s1, scl_s2, sda_s1, sda_s2;
  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop;

  // Stage p0: two-flop synchroniser; idle-high reset so reset never fakes an edge
  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= i_scl;
      scl_s2 <= scl_s1;
      sda_s1 <= i_sda;
      sda_s2 <= sda_s1;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [FILT_LEN-1:0] scl_h, sda_h;

  // Stage p1: output follows a line only after FILT_LEN identical samples
  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      scl_h <= '1;
      sda_h <= '1;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= (scl_h << 1) | FILT_LEN'(scl_s2);
      sda_h <= (sda_h << 1) | FILT_LEN'(sda_s2);
      if (&scl_h)       scl_f <= 1'b1;
      else if (~|scl_h) scl_f <= 1'b0;
      if (&sda_h)       sda_f <= 1'b1;
      else if (~|sda_h) sda_f <= 1'b0;
    end
  end
`else
  assign scl_f = scl_s2;
  assign sda_f = sda_s2;
`endif

  // Stage p2: previous-sample registers for edge and bus-condition detection
  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start    = scl_f & scl_d & sda_d & ~sda_f;
  assign stop     = scl_f & scl_d & ~sda_d & sda_f;
  assign rd_byte  = bank[ptr];

  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      state <= S_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      oe    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      oe    <= oe_nxt;
      busy  <= busy_nxt;
    end
  end

  always_ff @(posedge i_sysclk) begin
    sh <= sh_nxt;
    tx <= tx_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    tx_nxt    = tx;
    ptr_nxt   = ptr;
    oe_nxt    = oe;
    busy_nxt  = busy;
    bank_we   = 1'b0;
    if (start) begin
      state_nxt = S_DEV_ADDR;
      cnt_nxt   = '0;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b1;
    end else if (stop) begin
      state_nxt = S_IDLE;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        S_DEV_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            sh_nxt  = {sh[6:0], sda_f};
            cnt_nxt = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            oe_nxt = 1'b1;
            if (state == S_DEV_ADDR) begin
              if (sh[7:1] == DEV_ADDR) state_nxt = S_ACK_A;
              else begin
                state_nxt = S_IDLE;
                oe_nxt    = 1'b0;
              end
            end else if (state == S_PTR) begin
              ptr_nxt   = sh[AW-1:0];
              state_nxt = S_ACK_P;
            end else begin
              bank_we   = 1'b1;
              ptr_nxt   = ptr + AW'(1);
              state_nxt = S_ACK_W;
            end
          end
        end
        S_ACK_A: begin
          if (scl_fall) begin
            cnt_nxt = '0;
            if (sh[0]) begin
              // Byte is latched here, so later local writes cannot disturb it
              state_nxt = S_RDATA;
              tx_nxt    = rd_byte;
              oe_nxt    = ~rd_byte[7];
            end else begin
              state_nxt = S_PTR;
              oe_nxt    = 1'b0;
            end
          end
        end
        S_ACK_P, S_ACK_W: begin
          if (scl_fall) begin
            state_nxt = S_WDATA;
            cnt_nxt   = '0;
            oe_nxt    = 1'b0;
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (cnt == 4'd7) begin
              state_nxt = S_MACK;
              ptr_nxt   = ptr + AW'(1);
              cnt_nxt   = '0;
              oe_nxt    = 1'b0;
            end else begin
              tx_nxt  = {tx[6:0], 1'b0};
              oe_nxt  = ~tx[6];
              cnt_nxt = cnt + 4'd1;
            end
          end
        end
        S_MACK: begin
          if (scl_rise) sh_nxt = {sh[6:0], sda_f};
          else if (scl_fall) begin
            cnt_nxt = '0;
            if (!sh[0]) begin
              state_nxt = S_RDATA;
              tx_nxt    = rd_byte;
              oe_nxt    = ~rd_byte[7];
            end else begin
              state_nxt = S_IDLE;
              oe_nxt    = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c_we = bank_we & ~i_arst;

  // The I2C write is issued last so it wins a same-address collision
  always_ff @(posedge i_sysclk) begin
    if (i_usr_we) bank[i_usr_addr] <= i_usr_din;
    if (i2c_we)   bank[ptr]        <= sh;
  end

  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      o_wr_stb   <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_usr_dout <= '0;
    end else begin
      o_wr_stb   <= i2c_we;
      o_usr_dout <= bank[i_usr_addr];
      if (i2c_we) begin
        o_wr_addr <= ptr;
        o_wr_data <= sh;
      end
    end
  end

  assign o_sda_oe = oe;
  assign o_busy   = busy;

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Directed bench for i2c_target_regbank: bit-banged I2C controller plus local-port checks.
module tb_i2c_target_regbank;
  localparam int AW = 6;
  localparam int Q  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scl = 1'b1;
  logic          sda_low = 1'b0;
  logic          usr_we = 1'b0;
  logic [AW-1:0] usr_addr = '0;
  logic [7:0]    usr_din = '0;
  logic          sda_oe, wr_stb, busy, sda_bus;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, usr_dout;

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] stb_addr_q[$];
  logic [7:0]    stb_data_q[$];

  assign sda_bus = ~(sda_low | sda_oe);

  i2c_target_regbank #(.DEV_ADDR(7'h4C), .AW(AW), .FILT_LEN(3)) dut (
    .i_sysclk(clk), .i_arst(rst), .i_scl(scl), .i_sda(sda_bus),
    .o_sda_oe(sda_oe), .i_usr_we(usr_we), .i_usr_addr(usr_addr),
    .i_usr_din(usr_din), .o_usr_dout(usr_dout), .o_wr_stb(wr_stb),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_addr_q.push_back(wr_addr);
      stb_data_q.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_low = 1'b1; hq();
    scl = 1'b0; hq();
  endtask

  task automatic i2c_rstart();
    sda_low = 1'b0; hq();
    scl = 1'b1; hq();
    sda_low = 1'b1; hq();
    scl = 1'b0; hq();
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; hq();
    scl = 1'b1; hq();
    sda_low = 1'b0; hq();
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_low = ~b; hq();
    scl = 1'b1; hq();
    r = sda_bus; hq();
    scl = 1'b0; hq();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(1'b1, b[i]);
    bit_xfer(nack, r);
  endtask

  task automatic usr_rd(input logic [AW-1:0] a, output logic [7:0] d);
    usr_addr = a;
    @(negedge clk);
    @(negedge clk);
    d = usr_dout;
  endtask

  initial begin
    logic       ack, seen;
    logic [7:0] d;

    // Reset values
    repeat (5) @(negedge clk);
    check("rst_oe", sda_oe, 0);
    check("rst_stb", wr_stb, 0);
    check("rst_waddr", wr_addr, 0);
    check("rst_wdata", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", usr_dout, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 1: write ptr 05, data A1, B2
    i2c_start();
    check("t1_busy_start", busy, 1);
    wr_byte(8'h98, ack); check("t1_ack_addr", ack, 0);
    wr_byte(8'h05, ack); check("t1_ack_ptr", ack, 0);
    wr_byte(8'hA1, ack); check("t1_ack_d0", ack, 0);
    wr_byte(8'hB2, ack); check("t1_ack_d1", ack, 0);
    i2c_stop();
    check("t1_busy_stop", busy, 0);
    check("t1_stb_cnt", stb_addr_q.size(), 2);
    if (stb_addr_q.size() == 2) begin
      check("t1_stb0_addr", stb_addr_q[0], 6'h05);
      check("t1_stb0_data", stb_data_q[0], 8'hA1);
      check("t1_stb1_addr", stb_addr_q[1], 6'h06);
      check("t1_stb1_data", stb_data_q[1], 8'hB2);
    end
    stb_addr_q.delete(); stb_data_q.delete();
    usr_rd(6'h06, d); check("t1_local_rd6", d, 8'hB2);

    // 2: set ptr 05, repeated START, read two bytes (ACK then NACK)
    i2c_start();
    wr_byte(8'h98, ack); check("t2_ack_addr", ack, 0);
    wr_byte(8'h05, ack); check("t2_ack_ptr", ack, 0);
    i2c_rstart();
    wr_byte(8'h99, ack); check("t2_ack_raddr", ack, 0);
    rd_byte(1'b0, d); check("t2_rd0", d, 8'hA1);
    rd_byte(1'b1, d); check("t2_rd1", d, 8'hB2);
    check("t2_oe_after_nack", sda_oe, 0);
    check("t2_sda_released", sda_bus, 1);
    i2c_stop();
    check("t2_busy_stop", busy, 0);

    // 3: foreign address 0x33 is ignored
    i2c_start();
    wr_byte(8'h66, ack); check("t3_nack", ack, 1);
    check("t3_busy_mid", busy, 1);
    wr_byte(8'h00, ack); check("t3_no_drive", ack, 1);
    i2c_stop();
    check("t3_busy_stop", busy, 0);
    check("t3_no_stb", stb_addr_q.size(), 0);

    // 4: pointer wrap 3F -> 00
    i2c_start();
    wr_byte(8'h98, ack);
    wr_byte(8'h3F, ack);
    wr_byte(8'h11, ack); check("t4_ack_d0", ack, 0);
    wr_byte(8'h22, ack); check("t4_ack_d1", ack, 0);
    i2c_stop();
    check("t4_stb_cnt", stb_addr_q.size(), 2);
    if (stb_addr_q.size() == 2) begin
      check("t4_stb1_addr", stb_addr_q[1], 6'h00);
      check("t4_stb1_data", stb_data_q[1], 8'h22);
    end
    stb_addr_q.delete(); stb_data_q.delete();
    usr_rd(6'h3F, d); check("t4_bank63", d, 8'h11);
    usr_rd(6'h00, d); check("t4_bank0", d, 8'h22);

    // 5: local write held across the I2C write to 0x10
    i2c_start();
    wr_byte(8'h98, ack);
    wr_byte(8'h10, ack);
    usr_addr = 6'h10;
    usr_din  = 8'h5A;
    seen     = 1'b0;
    fork
      wr_byte(8'hC3, ack);
      begin
        usr_we = 1'b1;
        for (int k = 0; k < 2000 && !seen; k++) begin
          @(negedge clk);
          if (wr_stb === 1'b1) seen = 1'b1;
        end
        usr_we = 1'b0;
      end
    join
    check("t5_stb_seen", seen, 1);
    check("t5_ack", ack, 0);
    i2c_stop();
    usr_rd(6'h10, d); check("t5_collision", d, 8'hC3);
    stb_addr_q.delete(); stb_data_q.delete();

    // 6: reset during the read data phase, then read from pointer 0
    i2c_start();
    wr_byte(8'h98, ack);
    wr_byte(8'h3F, ack);
    i2c_rstart();
    wr_byte(8'h99, ack); check("t6_ack_raddr", ack, 0);
    check("t6_oe_bit7", sda_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_oe_after_rst", sda_oe, 0);
    check("t6_busy_after_rst", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_oe_ignored", sda_oe, 0);
    i2c_stop();
    i2c_start();
    wr_byte(8'h99, ack); check("t6_ack_after_rst", ack, 0);
    rd_byte(1'b1, d); check("t6_rd_ptr0", d, 8'h22);
    i2c_stop();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // 1-cycle SDA glitch with SCL high must not register as START
    repeat (10) @(negedge clk);
    sda_low = 1'b1;
    @(negedge clk);
    sda_low = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_no_start", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
